// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decides taken/not-taken, detects mispredicts,
// issues a one-cycle redirect/flush, and owns the 2-bit saturating BHT and statistics counters.
module branch_resolve_unit #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        stall,
    input  logic        breq,
    input  logic        brlt,
    output logic        unsigned_cmp,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_W;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       bht_d [ENTRIES];
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [31:0]      branch_count_q, branch_count_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;

    logic             resolve;
    logic             is_jump;
    logic             legal_branch;
    logic             cond_taken;
    logic             act_taken;
    logic             mispredict;
    logic [31:0]      act_next_pc;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] if_idx;
    logic             if_pc_unused;

    assign unsigned_cmp  = ex_funct3[1];
    assign ex_idx        = ex_pc[IDX_W+1:2];
    assign if_idx        = if_pc[IDX_W+1:2];
    assign if_pred_taken = bht_q[if_idx][1];
    assign if_pc_unused  = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Condition decode for conditional branches; 010/011 are illegal and inert
    always_comb begin
        legal_branch = 1'b0;
        cond_taken   = 1'b0;
        case (ex_funct3)
            3'b000: begin legal_branch = 1'b1; cond_taken = breq;  end
            3'b001: begin legal_branch = 1'b1; cond_taken = !breq; end
            3'b100: begin legal_branch = 1'b1; cond_taken = brlt;  end
            3'b110: begin legal_branch = 1'b1; cond_taken = brlt;  end
            3'b101: begin legal_branch = 1'b1; cond_taken = !brlt; end
            3'b111: begin legal_branch = 1'b1; cond_taken = !brlt; end
            default: begin legal_branch = 1'b0; cond_taken = 1'b0; end
        endcase
    end

    // Resolution, mispredict detection and next-state for redirect, BHT and counters
    always_comb begin
        // EX contents during a redirect cycle are wrong-path
        resolve = ex_valid & !stall & !redirect_valid_q;
        is_jump = ex_is_jalr | ex_is_jal;

        if (is_jump) begin
            act_taken = 1'b1;
        end else if (ex_is_branch & legal_branch) begin
            act_taken = cond_taken;
        end else begin
            act_taken = 1'b0;
        end

        if (!act_taken) begin
            act_next_pc = ex_pc + 32'd4;
        end else if (ex_is_jalr) begin
            act_next_pc = {ex_target[31:1], 1'b0};
        end else begin
            act_next_pc = ex_target;
        end

        mispredict = resolve & (is_jump | (ex_is_branch & legal_branch))
                     & (act_taken != ex_pred_taken);

        bht_d              = bht_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        redirect_valid_d   = mispredict;

        if (mispredict) begin
            redirect_pc_d      = act_next_pc;
            mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            redirect_pc_d = redirect_pc_q;
        end

        if (resolve & !is_jump & ex_is_branch & legal_branch) begin
            bht_d[ex_idx]  = sat_step(bht_q[ex_idx], cond_taken);
            branch_count_d = branch_count_q + 32'd1;
        end else begin
            branch_count_d = branch_count_q;
        end
    end

    // State registers; reset drops any pending redirect and sets BHT weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 32'd0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign flush            = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch comparator's breq/brlt outputs.
- Decodes funct3 and drives the comparator's unsigned_cmp select.
- Decides taken/not-taken for conditional branches and JAL/JALR, detects mispredicts against the fetch-time prediction, and issues a registered one-cycle redirect/flush to fetch.
- Owns the 2-bit saturating branch history table (BHT) read by fetch, and keeps branch and mispredict statistics counters.

Parameters:
- IDX_W, 4, BHT index width; table holds 2^IDX_W entries of 2 bits each.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX holds a valid control-flow instruction
- ex_is_branch  in  1  conditional branch (funct3 meaningful)
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch funct3
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed target (pc+imm, or rs1+imm for JALR)
- ex_pred_taken  in  1  prediction carried down the pipe from fetch
- stall  in  1  EX is frozen this cycle
- breq  in  1  comparator equal result
- brlt  in  1  comparator less-than result
- unsigned_cmp  out  1  comparator mode select; 0 = signed, 1 = unsigned
- if_pc  in  32  fetch PC for BHT lookup
- if_pred_taken  out  1  BHT prediction for if_pc
- redirect_valid  out  1  one-cycle redirect pulse to fetch
- redirect_pc  out  32  corrected next PC
- flush  out  1  kill IF/ID wrong-path instructions; equals redirect_valid
- branch_count  out  32  resolved conditional branches
- mispredict_count  out  32  total mispredicts

Behaviour:
- Reset (asynchronous, effective immediately, including mid-operation):
  - redirect_valid=0, flush=0, redirect_pc=0, both counters=0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Any pending redirect is dropped.
- unsigned_cmp = ex_funct3[1]. Combinational, no gating.
- Resolve event: ex_valid & !stall & !redirect_valid.
  - In the redirect cycle, the EX contents are wrong-path and are ignored: no update, no count.
- Actual taken (conditional branch):
  - 000 = breq
  - 001 = !breq
  - 100 / 110 = brlt
  - 101 / 111 = !brlt
  - 010 / 011 are illegal: not taken, no BHT update, not counted, never mispredict.
- JAL and JALR are always taken.
- Actual next PC:
  - taken: ex_target, with bit 0 forced to 0 for JALR
  - not taken: ex_pc + 4, modulo 2^32 (wraps)
- Mispredict: actual taken != ex_pred_taken. Target correctness is not checked.
- Redirect timing, on a mispredicting resolve event at edge N:
  - During cycle N+1: redirect_valid=1, flush=1, redirect_pc = actual next PC.
  - Both deassert at edge N+2 unless re-triggered.
  - Because redirect_valid blocks resolve, back-to-back pulses cannot occur.
  - redirect_pc holds its last value when redirect_valid=0.
- BHT read: if_pred_taken = BHT[if_pc[IDX_W+1:2]][1]. Combinational.
  - On a same-cycle read/write of one entry, the read returns the pre-update value.
- BHT update: on a resolve event for a legal conditional branch only; index = ex_pc[IDX_W+1:2].
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
  - JAL/JALR never update the BHT.
- Counters, written at the resolve edge; both wrap at 2^32:
  - branch_count += 1 per legal conditional branch resolve.
  - mispredict_count += 1 per mispredicting resolve (any type).
- stall=1: no update, no count, no new redirect. A pulse already asserted still completes its single cycle.
- Multiple ex_is_* asserted together is illegal. Priority is jalr > jal > branch.
- ex_valid with no ex_is_* set: no action.

Test Plan:
- Reset → BHT lookup for if_pc=0x00000040 gives if_pred_taken=0; assert ex_valid, ex_is_branch, funct3=000, breq=1, pred=0, ex_pc=0x40, target=0x80 → at N+1 redirect_valid=1, redirect_pc=0x80, flush=1; BHT[0] moves 01→10; if_pred_taken for 0x40 reads 1 from N+1; mispredict_count=1, branch_count=1.
- funct3=111 with brlt=0, pred=1, ex_pc=0x100 → unsigned_cmp=1, no redirect, branch_count increments, mispredict_count unchanged.
- JALR, pred=0, target=0x00001235 → redirect_pc=0x00001234; BHT unchanged; branch_count unchanged; mispredict_count +1.
- Mispredict at edge N with a new ex_valid present in cycle N+1 → that instruction is ignored (no count, no BHT change); single-cycle pulse only.
- Four consecutive taken branches at ex_pc=0x40 → entry saturates at 11; four not-taken → saturates at 00; no wrap in either direction.
- rst asserted mid-cycle during an active redirect → redirect_valid/flush drop immediately without a clock edge; counters read 0; BHT entry for 0x40 reads 01 (if_pred_taken=0); stall=1 with ex_valid=1 during normal operation → no state change.
